// File: rtl/fft_pkg.sv
// Shared FFT definitions: default widths, butterfly latency, complex sample type
// and the saturation helpers used by the butterfly output stage.
package fft_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int TW_WIDTH_DEF   = 16;
    localparam int TAG_WIDTH_DEF  = 8;
    localparam int BFU_LATENCY    = 4;

    typedef struct packed {
        logic signed [DATA_WIDTH_DEF-1:0] re;
        logic signed [DATA_WIDTH_DEF-1:0] im;
    } cplx_t;

    // Clamp a sign-extended value to the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_val(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    function automatic logic sat_hit(input logic signed [63:0] x, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (x > hi) || (x < lo);
    endfunction

endpackage

// File: rtl/bfu_delay_line.sv
// Parametrised depth/width shift register with clock enable and synchronous clear.
module bfu_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH:0][WIDTH-1:0] chain;

    assign chain[0] = din;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_tap
            logic [WIDTH-1:0] tap_d;
            logic [WIDTH-1:0] tap_q;

            always_comb begin
                tap_d = en ? chain[gi] : tap_q;
            end

            always_ff @(posedge clk) begin
                if (clr) begin
                    tap_q <= '0;
                end else begin
                    tap_q <= tap_d;
                end
            end

            assign chain[gi+1] = tap_q;
        end
    endgenerate

    assign dout = chain[DEPTH];

endmodule

// File: rtl/bfu_pipe.sv
// Streaming 4-stage radix-2 DIT butterfly with tag sideband, stall, inverse mode,
// scale-by-half, saturation and sticky overflow. Define BFU_ROUND_EN for round-half-up shifts.
module bfu_pipe
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int TW_WIDTH   = TW_WIDTH_DEF,
    parameter int TAG_WIDTH  = TAG_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic        [TAG_WIDTH-1:0]  in_tag,
    input  logic                         inverse,
    input  logic                         scale,
    input  logic signed [DATA_WIDTH-1:0] a_in_r,
    input  logic signed [DATA_WIDTH-1:0] a_in_i,
    input  logic signed [DATA_WIDTH-1:0] b_in_r,
    input  logic signed [DATA_WIDTH-1:0] b_in_i,
    input  logic signed [TW_WIDTH-1:0]   tw_r,
    input  logic signed [TW_WIDTH-1:0]   tw_i,
    input  logic                         ovf_clr,
    output logic                         out_valid,
    output logic        [TAG_WIDTH-1:0]  out_tag,
    output logic signed [DATA_WIDTH-1:0] a_out_r,
    output logic signed [DATA_WIDTH-1:0] a_out_i,
    output logic signed [DATA_WIDTH-1:0] b_out_r,
    output logic signed [DATA_WIDTH-1:0] b_out_i,
    output logic                         ovf
);

    localparam int PW    = DATA_WIDTH + TW_WIDTH;
    localparam int XW    = PW + 2;
    localparam int QW    = DATA_WIDTH + 2;
    localparam int SW    = DATA_WIDTH + 3;
    localparam int FW    = SW + 1;
    localparam int SHIFT = TW_WIDTH - 1;
    localparam int SBW   = TAG_WIDTH + 2;

    localparam logic signed [XW-1:0] P_RND = XW'(1) <<< (SHIFT - 1);
    localparam logic signed [FW-1:0] S_RND = FW'(1);

    // ---------------- stage 1: partial products ----------------
    logic signed [PW-1:0] p_rr_d, p_rr_q, p_ii_d, p_ii_q;
    logic signed [PW-1:0] p_ri_d, p_ri_q, p_ir_d, p_ir_q;
    logic                 inv_d, inv_q;

    always_comb begin
        p_rr_d = p_rr_q;
        p_ii_d = p_ii_q;
        p_ri_d = p_ri_q;
        p_ir_d = p_ir_q;
        inv_d  = inv_q;
        if (en) begin
            p_rr_d = PW'(b_in_r) * PW'(tw_r);
            p_ii_d = PW'(b_in_i) * PW'(tw_i);
            p_ri_d = PW'(b_in_r) * PW'(tw_i);
            p_ir_d = PW'(b_in_i) * PW'(tw_r);
            inv_d  = inverse;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ri_q <= '0;
            p_ir_q <= '0;
            inv_q  <= 1'b0;
        end else begin
            p_rr_q <= p_rr_d;
            p_ii_q <= p_ii_d;
            p_ri_q <= p_ri_d;
            p_ir_q <= p_ir_d;
            inv_q  <= inv_d;
        end
    end

    // ---------------- stage 2: complex combine and rescale ----------------
    logic signed [XW-1:0] sum_r, sum_i;
    logic signed [QW-1:0] p_r_d, p_r_q, p_i_d, p_i_q;

    always_comb begin
        // Inverse uses conj(W): the Bi*Wi and Br*Wi terms change sign.
        if (inv_q) begin
            sum_r = XW'(p_rr_q) + XW'(p_ii_q);
            sum_i = XW'(p_ir_q) - XW'(p_ri_q);
        end else begin
            sum_r = XW'(p_rr_q) - XW'(p_ii_q);
            sum_i = XW'(p_ri_q) + XW'(p_ir_q);
        end
`ifdef BFU_ROUND_EN
        sum_r = sum_r + P_RND;
        sum_i = sum_i + P_RND;
`endif
        p_r_d = p_r_q;
        p_i_d = p_i_q;
        if (en) begin
            p_r_d = QW'(sum_r >>> SHIFT);
            p_i_d = QW'(sum_i >>> SHIFT);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            p_r_q <= '0;
            p_i_q <= '0;
        end else begin
            p_r_q <= p_r_d;
            p_i_q <= p_i_d;
        end
    end

    // ---------------- A operand and sideband alignment ----------------
    logic [2*DATA_WIDTH-1:0]      a_s2;
    logic signed [DATA_WIDTH-1:0] a_s2_r, a_s2_i;
    logic [SBW-1:0]               sb_s3;
    logic                         s3_valid, s3_scale;
    logic [TAG_WIDTH-1:0]         s3_tag;

    bfu_delay_line #(
        .DEPTH (2),
        .WIDTH (2 * DATA_WIDTH)
    ) u_a_dly (
        .clk  (clk),
        .clr  (clr),
        .en   (en),
        .din  ({a_in_r, a_in_i}),
        .dout (a_s2)
    );

    bfu_delay_line #(
        .DEPTH (3),
        .WIDTH (SBW)
    ) u_sb_dly (
        .clk  (clk),
        .clr  (clr),
        .en   (en),
        .din  ({in_valid, scale, in_tag}),
        .dout (sb_s3)
    );

    assign a_s2_r   = a_s2[2*DATA_WIDTH-1:DATA_WIDTH];
    assign a_s2_i   = a_s2[DATA_WIDTH-1:0];
    assign s3_valid = sb_s3[SBW-1];
    assign s3_scale = sb_s3[SBW-2];
    assign s3_tag   = sb_s3[TAG_WIDTH-1:0];

    // ---------------- stage 3: butterfly sums ----------------
    logic signed [SW-1:0] sa_r_d, sa_r_q, sa_i_d, sa_i_q;
    logic signed [SW-1:0] sb_r_d, sb_r_q, sb_i_d, sb_i_q;

    always_comb begin
        sa_r_d = sa_r_q;
        sa_i_d = sa_i_q;
        sb_r_d = sb_r_q;
        sb_i_d = sb_i_q;
        if (en) begin
            sa_r_d = SW'(a_s2_r) + SW'(p_r_q);
            sa_i_d = SW'(a_s2_i) + SW'(p_i_q);
            sb_r_d = SW'(a_s2_r) - SW'(p_r_q);
            sb_i_d = SW'(a_s2_i) - SW'(p_i_q);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sa_r_q <= '0;
            sa_i_q <= '0;
            sb_r_q <= '0;
            sb_i_q <= '0;
        end else begin
            sa_r_q <= sa_r_d;
            sa_i_q <= sa_i_d;
            sb_r_q <= sb_r_d;
            sb_i_q <= sb_i_d;
        end
    end

    // ---------------- stage 4: scale, saturate, overflow ----------------
    logic signed [SW-1:0]         s3_vec [4];
    logic signed [FW-1:0]         f_vec  [4];
    logic [3:0]                   clip;
    logic signed [DATA_WIDTH-1:0] out_d  [4];
    logic signed [DATA_WIDTH-1:0] out_q  [4];
    logic                         out_valid_d, out_valid_q;
    logic [TAG_WIDTH-1:0]         out_tag_d, out_tag_q;
    logic                         ovf_d, ovf_q;

    assign s3_vec[0] = sa_r_q;
    assign s3_vec[1] = sa_i_q;
    assign s3_vec[2] = sb_r_q;
    assign s3_vec[3] = sb_i_q;

    always_comb begin
        out_valid_d = out_valid_q;
        out_tag_d   = out_tag_q;
        ovf_d       = ovf_q;
        clip        = '0;
        for (int k = 0; k < 4; k++) begin
            f_vec[k] = FW'(s3_vec[k]);
            if (s3_scale) begin
`ifdef BFU_ROUND_EN
                f_vec[k] = f_vec[k] + S_RND;
`endif
                f_vec[k] = f_vec[k] >>> 1;
            end
            clip[k]  = sat_hit(64'(f_vec[k]), DATA_WIDTH);
            out_d[k] = out_q[k];
        end
        if (en) begin
            out_valid_d = s3_valid;
            out_tag_d   = s3_tag;
            for (int k = 0; k < 4; k++) begin
                out_d[k] = DATA_WIDTH'(sat_val(64'(f_vec[k]), DATA_WIDTH));
            end
            // A clip on a real sample takes priority over a clear in the same cycle.
            if (ovf_clr) begin
                ovf_d = 1'b0;
            end
            if (s3_valid && (|clip)) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            ovf_q       <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                out_q[k] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            ovf_q       <= ovf_d;
            for (int k = 0; k < 4; k++) begin
                out_q[k] <= out_d[k];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_tag   = out_tag_q;
    assign a_out_r   = out_q[0];
    assign a_out_i   = out_q[1];
    assign b_out_r   = out_q[2];
    assign b_out_i   = out_q[3];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bfu_pipe.sv
// Directed-vector bench for bfu_pipe: a scoreboard checks every emitted butterfly
// (values, tag, order, enabled-cycle latency); flag and reset behaviour are checked inline.
module tb_bfu_pipe;
    import fft_pkg::*;

`ifdef BFU_ROUND_EN
    localparam int T1_AR = 3000;
    localparam int T1_BR = 1000;
    localparam int T4_AR = 32767;
    localparam int T4_BR = 1;
`else
    localparam int T1_AR = 2999;
    localparam int T1_BR = 1001;
    localparam int T4_AR = 32766;
    localparam int T4_BR = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               clr, en, in_valid, inverse, scale, ovf_clr;
    logic        [7:0]  in_tag;
    logic signed [15:0] a_in_r, a_in_i, b_in_r, b_in_i, tw_r, tw_i;
    logic               out_valid, ovf;
    logic        [7:0]  out_tag;
    logic signed [15:0] a_out_r, a_out_i, b_out_r, b_out_i;

    bfu_pipe dut (
        .clk       (clk),
        .clr       (clr),
        .en        (en),
        .in_valid  (in_valid),
        .in_tag    (in_tag),
        .inverse   (inverse),
        .scale     (scale),
        .a_in_r    (a_in_r),
        .a_in_i    (a_in_i),
        .b_in_r    (b_in_r),
        .b_in_i    (b_in_i),
        .tw_r      (tw_r),
        .tw_i      (tw_i),
        .ovf_clr   (ovf_clr),
        .out_valid (out_valid),
        .out_tag   (out_tag),
        .a_out_r   (a_out_r),
        .a_out_i   (a_out_i),
        .b_out_r   (b_out_r),
        .b_out_i   (b_out_i),
        .ovf       (ovf)
    );

    typedef struct {
        logic [7:0] tag;
        cplx_t      a;
        cplx_t      b;
        int         due;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   ecnt     = 0;

    task automatic chk_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    always @(posedge clk) begin
        if (en && !clr) ecnt <= ecnt + 1;
    end

    // Scoreboard: an output is consumed in a cycle where en is high.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1 && en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk_val($sformatf("spurious_valid tag%02h", out_tag), out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk_val($sformatf("t%02h_tag", e.tag), out_tag, e.tag);
                chk_val($sformatf("t%02h_a_r", e.tag), a_out_r, e.a.re);
                chk_val($sformatf("t%02h_a_i", e.tag), a_out_i, e.a.im);
                chk_val($sformatf("t%02h_b_r", e.tag), b_out_r, e.b.re);
                chk_val($sformatf("t%02h_b_i", e.tag), b_out_i, e.b.im);
                chk_val($sformatf("t%02h_latency", e.tag), ecnt, e.due);
                $display("out tag=%02h A'=(%0d,%0d) B'=(%0d,%0d) ovf=%0b",
                         out_tag, a_out_r, a_out_i, b_out_r, b_out_i, ovf);
            end
        end
    end

    task automatic send(input logic v, input logic [7:0] tag,
                        input int ar, input int ai, input int br, input int bi,
                        input int wr, input int wi, input logic inv, input logic scl,
                        input int xar, input int xai, input int xbr, input int xbi);
        exp_t e;
        in_valid = v;
        in_tag   = tag;
        a_in_r   = 16'(ar);
        a_in_i   = 16'(ai);
        b_in_r   = 16'(br);
        b_in_i   = 16'(bi);
        tw_r     = 16'(wr);
        tw_i     = 16'(wi);
        inverse  = inv;
        scale    = scl;
        if (v && en && !clr) begin
            e.tag   = tag;
            e.a.re  = 16'(xar);
            e.a.im  = 16'(xai);
            e.b.re  = 16'(xbr);
            e.b.im  = 16'(xbi);
            e.due   = ecnt + 4;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) send(1'b0, 8'h00, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            idle(1);
            k++;
        end
        if (exp_q.size() != 0) begin
            chk_val("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr     = 1'b1;
        en      = 1'b1;
        ovf_clr = 1'b0;
        idle(2);
        chk_val("reset_out_valid", out_valid, 0);
        chk_val("reset_out_tag", out_tag, 0);
        chk_val("reset_a_out_r", a_out_r, 0);
        chk_val("reset_b_out_r", b_out_r, 0);
        chk_val("reset_ovf", ovf, 0);
        clr = 1'b0;

        // Basic latency / arithmetic
        send(1'b1, 8'h5A, 2000, 0, 1000, 0, 32767, 0, 1'b0, 1'b0, T1_AR, 0, T1_BR, 0);
        drain();
        chk_val("basic_ovf", ovf, 0);

        // Twiddle -j, forward then inverse, back to back
        send(1'b1, 8'h01, 0, 0, 1000, 500, 0, -32768, 1'b0, 1'b0, 500, -1000, -500, 1000);
        send(1'b1, 8'h02, 0, 0, 1000, 500, 0, -32768, 1'b1, 1'b0, -500, 1000, 500, -1000);
        drain();

        // Saturation and scale
        send(1'b1, 8'h03, 32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b0, 32767, 0, 1, 0);
        drain();
        chk_val("sat_pos_ovf", ovf, 1);
        send(1'b1, 8'h04, 32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b1, T4_AR, 0, T4_BR, 0);
        drain();
        chk_val("scale_ovf_hold", ovf, 1);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        chk_val("ovf_cleared", ovf, 0);
        send(1'b1, 8'h05, -32768, 0, 32767, 0, 32767, 0, 1'b0, 1'b0, -2, 0, -32768, 0);
        drain();
        chk_val("sat_neg_ovf", ovf, 1);

        // Stall: 8 back-to-back samples, en low for 3 cycles mid-stream
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                en = 1'b0;
                repeat (3) send(1'b1, 8'(8'h10 + i), 100 * i, -50 * i, 20 * i, 10 * i,
                                16384, 0, 1'b0, 1'b0, 0, 0, 0, 0);
                en = 1'b1;
            end
            send(1'b1, 8'(8'h10 + i), 100 * i, -50 * i, 20 * i, 10 * i, 16384, 0, 1'b0, 1'b0,
                 110 * i, -45 * i, 90 * i, -55 * i);
        end
        drain();
        chk_val("stall_ovf_hold", ovf, 1);

        // Reset with 3 samples in flight
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 8'(8'h20 + i), 1000, 1000, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 0);
        end
        exp_q.delete();
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        chk_val("midrst_out_valid", out_valid, 0);
        chk_val("midrst_a_out_r", a_out_r, 0);
        chk_val("midrst_a_out_i", a_out_i, 0);
        chk_val("midrst_ovf", ovf, 0);
        for (int i = 0; i < 6; i++) begin
            idle(1);
            chk_val($sformatf("midrst_no_stale%0d", i), out_valid, 0);
        end

        // Bubbles carrying saturating operands
        repeat (6) send(1'b0, 8'h30, 32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b0, 0, 0, 0, 0);
        chk_val("bubble_ovf", ovf, 0);
        chk_val("bubble_out_valid", out_valid, 0);
        idle(2);
        chk_val("bubble_ovf_late", ovf, 0);

        chk_val("leftover_expected", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
